// File: rtl/morse_key_receiver_if.sv
// morse_key_receiver_if
// Groups the key input, unit selection and decoded-symbol outputs of the
// Morse key receiver into one bundle.
//   key        : debounced key level, 1 = pressed (asynchronous to clk)
//   unit_sel   : unit length select, U = BASE_UNIT << unit_sel ticks
//   sym_bits   : symbols of current/last letter, bit0 first, 1 = dash
//   sym_len    : number of valid symbols in sym_bits (0..5)
//   char_valid : one-cycle pulse, char_code valid
//   char_code  : 0-9 digits, 10-35 A-Z, 63 invalid/error
//   word_gap   : one-cycle pulse on word space
//   err        : sticky per letter (overflow or stuck key)
// master = key source / display consumer, slave = receiver.
interface morse_key_receiver_if;
  logic       key;
  logic [1:0] unit_sel;
  logic [4:0] sym_bits;
  logic [2:0] sym_len;
  logic       char_valid;
  logic [5:0] char_code;
  logic       word_gap;
  logic       err;

  modport master (
    output key, unit_sel,
    input  sym_bits, sym_len, char_valid, char_code, word_gap, err
  );

  modport slave (
    input  key, unit_sel,
    output sym_bits, sym_len, char_valid, char_code, word_gap, err
  );
endinterface

// File: rtl/morse_key_receiver.sv
// morse_key_receiver
// Timing-based Morse receiver for a straight key. Press lengths are
// classified as dot/dash against a latched unit U, gaps delimit letters
// (3U) and words (7U), and finished letters are looked up in the ITU table.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : morse_key_receiver_if.slave (key/unit_sel in, symbol/char out)
module morse_key_receiver #(
  parameter int TICK_DIV  = 100000,
  parameter int BASE_UNIT = 60,
  parameter int MIN_PRESS = 10
) (
  input logic                 clk,
  input logic                 rst,
  morse_key_receiver_if.slave bus
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MARK  = 3'd1,
    S_SPACE = 3'd2,
    S_WAITW = 3'd3,
    S_STUCK = 3'd4
  } state_t;

  logic          key_meta_q, key_sync_q, key_prev_q;
  logic          rise_s, fall_s, edge_s, tick_s;
  logic [TW-1:0] tick_cnt_q;
  logic [11:0]   dur_q;
  logic [14:0]   dur_ext_s, dur_inc_s, u1_s, u2_s, u3_s, u7_s;
  state_t        state_q, state_d;
  logic [11:0]   unit_q, unit_d;
  logic [4:0]    sym_bits_q, sym_bits_d;
  logic [2:0]    sym_len_q, sym_len_d;
  logic          err_q, err_d;
  logic          char_valid_q, char_valid_d;
  logic [5:0]    char_code_q, char_code_d;
  logic          word_gap_q, word_gap_d;

  // ITU table: {length, symbols with bit0 first, 1 = dash} -> character code
  function automatic logic [5:0] morse_lookup(input logic [2:0] len, input logic [4:0] bits);
    logic [5:0] code;
    case ({len, bits})
      8'b001_00000: code = 6'd14; // E
      8'b001_00001: code = 6'd29; // T
      8'b010_00010: code = 6'd10; // A
      8'b010_00000: code = 6'd18; // I
      8'b010_00011: code = 6'd22; // M
      8'b010_00001: code = 6'd23; // N
      8'b011_00001: code = 6'd13; // D
      8'b011_00011: code = 6'd16; // G
      8'b011_00101: code = 6'd20; // K
      8'b011_00111: code = 6'd24; // O
      8'b011_00010: code = 6'd27; // R
      8'b011_00000: code = 6'd28; // S
      8'b011_00100: code = 6'd30; // U
      8'b011_00110: code = 6'd32; // W
      8'b100_00001: code = 6'd11; // B
      8'b100_00101: code = 6'd12; // C
      8'b100_00100: code = 6'd15; // F
      8'b100_00000: code = 6'd17; // H
      8'b100_01110: code = 6'd19; // J
      8'b100_00010: code = 6'd21; // L
      8'b100_00110: code = 6'd25; // P
      8'b100_01011: code = 6'd26; // Q
      8'b100_01000: code = 6'd31; // V
      8'b100_01001: code = 6'd33; // X
      8'b100_01101: code = 6'd34; // Y
      8'b100_00011: code = 6'd35; // Z
      8'b101_11111: code = 6'd0;
      8'b101_11110: code = 6'd1;
      8'b101_11100: code = 6'd2;
      8'b101_11000: code = 6'd3;
      8'b101_10000: code = 6'd4;
      8'b101_00000: code = 6'd5;
      8'b101_00001: code = 6'd6;
      8'b101_00011: code = 6'd7;
      8'b101_00111: code = 6'd8;
      8'b101_01111: code = 6'd9;
      default:      code = 6'd63;
    endcase
    return code;
  endfunction

  // Edges are taken on the synchronized level against its previous value.
  assign rise_s = key_sync_q & ~key_prev_q;
  assign fall_s = ~key_sync_q & key_prev_q;
  assign edge_s = key_sync_q ^ key_prev_q;
  assign tick_s = (tick_cnt_q == TW'(TICK_DIV - 1));

  // Thresholds in ticks; dur_inc_s is the value dur takes after this tick,
  // so the transition lands on the same edge where dur reaches it.
  assign dur_ext_s = {3'b000, dur_q};
  assign dur_inc_s = dur_ext_s + 15'd1;
  assign u1_s      = {3'b000, unit_q};
  assign u2_s      = u1_s << 1;
  assign u3_s      = u2_s + u1_s;
  assign u7_s      = (u1_s << 3) - u1_s;

  // Two-flop synchronizer plus previous-level flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_meta_q <= 1'b0;
      key_sync_q <= 1'b0;
      key_prev_q <= 1'b0;
    end else begin
      key_meta_q <= bus.key;
      key_sync_q <= key_meta_q;
      key_prev_q <= key_sync_q;
    end
  end

  // Tick prescaler and saturating duration counter cleared on key edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
      dur_q      <= 12'd0;
    end else begin
      tick_cnt_q <= tick_s ? '0 : tick_cnt_q + TW'(1);
      if (edge_s) begin
        dur_q <= 12'd0;
      end else if (tick_s && (dur_q != 12'hFFF)) begin
        dur_q <= dur_q + 12'd1;
      end else begin
        dur_q <= dur_q;
      end
    end
  end

  // State and letter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      unit_q       <= 12'd0;
      sym_bits_q   <= 5'd0;
      sym_len_q    <= 3'd0;
      err_q        <= 1'b0;
      char_valid_q <= 1'b0;
      char_code_q  <= 6'd0;
      word_gap_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      unit_q       <= unit_d;
      sym_bits_q   <= sym_bits_d;
      sym_len_q    <= sym_len_d;
      err_q        <= err_d;
      char_valid_q <= char_valid_d;
      char_code_q  <= char_code_d;
      word_gap_q   <= word_gap_d;
    end
  end

  // Next-state logic; key edges take priority over tick-driven timeouts
  always_comb begin
    state_d      = state_q;
    unit_d       = unit_q;
    sym_bits_d   = sym_bits_q;
    sym_len_d    = sym_len_q;
    err_d        = err_q;
    char_valid_d = 1'b0;
    char_code_d  = char_code_q;
    word_gap_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise_s) begin
          state_d    = S_MARK;
          sym_bits_d = 5'd0;
          sym_len_d  = 3'd0;
          err_d      = 1'b0;
          unit_d     = 12'(BASE_UNIT) << bus.unit_sel;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MARK: begin
        if (fall_s) begin
          if (dur_ext_s < 15'(MIN_PRESS)) begin
            state_d = (sym_len_q != 3'd0) ? S_SPACE : S_IDLE;
          end else if (sym_len_q == 3'd5) begin
            err_d   = 1'b1;
            state_d = S_SPACE;
          end else begin
            sym_bits_d[sym_len_q] = (dur_ext_s >= u2_s);
            sym_len_d             = sym_len_q + 3'd1;
            state_d               = S_SPACE;
          end
        end else if (tick_s && (dur_inc_s >= u7_s)) begin
          err_d   = 1'b1;
          state_d = S_STUCK;
        end else begin
          state_d = S_MARK;
        end
      end
      S_STUCK: begin
        if (fall_s) begin
          state_d = S_SPACE;
        end else begin
          state_d = S_STUCK;
        end
      end
      S_SPACE: begin
        if (rise_s && (dur_ext_s < u3_s)) begin
          state_d = S_MARK;
        end else if (tick_s && (dur_inc_s >= u3_s)) begin
          char_valid_d = 1'b1;
          char_code_d  = err_q ? 6'd63 : morse_lookup(sym_len_q, sym_bits_q);
          state_d      = S_WAITW;
        end else begin
          state_d = S_SPACE;
        end
      end
      S_WAITW: begin
        if (rise_s) begin
          state_d    = S_MARK;
          sym_bits_d = 5'd0;
          sym_len_d  = 3'd0;
          err_d      = 1'b0;
          unit_d     = 12'(BASE_UNIT) << bus.unit_sel;
        end else if (tick_s && (dur_inc_s >= u7_s)) begin
          word_gap_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_WAITW;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.sym_bits   = sym_bits_q;
  assign bus.sym_len    = sym_len_q;
  assign bus.char_valid = char_valid_q;
  assign bus.char_code  = char_code_q;
  assign bus.word_gap   = word_gap_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_morse_key_receiver.sv
// tb_morse_key_receiver
// Drives Morse letters as key press/gap durations (in ticks) and compares
// the receiver outputs against a string-based model built from the ITU
// alphabet. TICK_DIV=4, BASE_UNIT=8, MIN_PRESS=2, so U=8 ticks at unit_sel=0.
module tb_morse_key_receiver;
  localparam int TD = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cv_cnt, wg_cnt, cv_exp, wg_exp;
  logic [5:0] last_code;

  string morse_tbl [36] = '{
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----.",
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..",
    "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
    "-.--", "--.."
  };

  morse_key_receiver_if bus();

  morse_key_receiver #(
    .TICK_DIV  (TD),
    .BASE_UNIT (8),
    .MIN_PRESS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse monitor: counts every cycle each pulse output is high
  always @(negedge clk) begin
    if (bus.char_valid === 1'b1) begin
      cv_cnt++;
      last_code = bus.char_code;
    end
    if (bus.word_gap === 1'b1) wg_cnt++;
  end

  function automatic int model_code(input string pat);
    if (pat.len() > 5) return 63;
    for (int i = 0; i < 36; i++) if (morse_tbl[i] == pat) return i;
    return 63;
  endfunction

  function automatic logic [4:0] model_bits(input string pat);
    logic [4:0] b;
    b = 5'd0;
    for (int i = 0; i < pat.len() && i < 5; i++) b[i] = (pat[i] == "-");
    return b;
  endfunction

  function automatic int model_len(input string pat);
    return (pat.len() > 5) ? 5 : pat.len();
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * TD) @(negedge clk);
  endtask

  // dot_t/dash_t of 0 pick random lengths well inside the dot/dash windows
  task automatic send_letter(input string pat, input int dot_t, input int dash_t,
                             input int sgap, input int lgap, input bit scramble);
    for (int i = 0; i < pat.len(); i++) begin
      int d;
      if (pat[i] == "-") d = (dash_t > 0) ? dash_t : $urandom_range(19, 50);
      else               d = (dot_t > 0) ? dot_t : $urandom_range(3, 13);
      bus.key = 1'b1;
      if (i == 0 && scramble) begin
        wait_ticks(2);
        bus.unit_sel = 2'($urandom_range(1, 3));
        wait_ticks(d - 2);
      end else begin
        wait_ticks(d);
      end
      bus.key = 1'b0;
      if (i < pat.len() - 1) wait_ticks((sgap > 0) ? sgap : $urandom_range(3, 20));
    end
    wait_ticks(lgap);
    bus.unit_sel = 2'd0;
  endtask

  task automatic chk_letter(input string tag, input string pat);
    chk({tag, ".cv"}, cv_cnt, cv_exp);
    chk({tag, ".code"}, last_code, model_code(pat));
    chk({tag, ".hold"}, bus.char_code, model_code(pat));
    chk({tag, ".len"}, bus.sym_len, model_len(pat));
    chk({tag, ".bits"}, bus.sym_bits, model_bits(pat));
    chk({tag, ".err"}, bus.err, (pat.len() > 5) ? 1 : 0);
    chk({tag, ".wg"}, wg_cnt, wg_exp);
  endtask

  initial begin
    checks = 0; errors = 0;
    cv_cnt = 0; wg_cnt = 0; cv_exp = 0; wg_exp = 0;
    last_code = 6'd0;
    rst = 1'b0;
    bus.key = 1'b0;
    bus.unit_sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst.bits", bus.sym_bits, 0);
    chk("rst.len", bus.sym_len, 0);
    chk("rst.code", bus.char_code, 0);
    chk("rst.pulses", {bus.char_valid, bus.word_gap, bus.err}, 0);
    rst = 1'b1;
    wait_ticks(5);

    // E: single dot, then word gap exactly once
    send_letter(".", 8, 24, 8, 30, 1'b0);
    cv_exp++;
    chk_letter("E", ".");
    wait_ticks(30);
    wg_exp++;
    chk("E.wg_after", wg_cnt, wg_exp);
    wait_ticks(60);
    chk("E.quiet_cv", cv_cnt, cv_exp);
    chk("E.quiet_wg", wg_cnt, wg_exp);

    // A at x1, then at x4 with all durations scaled
    send_letter(".-", 8, 24, 8, 30, 1'b0);
    cv_exp++;
    chk_letter("A1", ".-");
    wait_ticks(34); wg_exp++;
    bus.unit_sel = 2'd2;
    send_letter(".-", 32, 96, 32, 120, 1'b0);
    cv_exp++;
    chk_letter("A4", ".-");
    wait_ticks(120); wg_exp++;
    chk("A4.wg", wg_cnt, wg_exp);
    bus.unit_sel = 2'd0;

    // digits 0 and 5
    send_letter("-----", 8, 24, 8, 30, 1'b0);
    cv_exp++;
    chk_letter("D0", "-----");
    wait_ticks(34); wg_exp++;
    send_letter(".....", 8, 24, 8, 30, 1'b0);
    cv_exp++;
    chk_letter("D5", ".....");
    wait_ticks(34); wg_exp++;

    // six dots: overflow on the 6th release
    send_letter(".....", 8, 24, 8, 8, 1'b0);
    chk("ovf.err5", bus.err, 0);
    bus.key = 1'b1; wait_ticks(8); bus.key = 1'b0;
    wait_ticks(2);
    chk("ovf.err6", bus.err, 1);
    chk("ovf.len6", bus.sym_len, 5);
    wait_ticks(28);
    cv_exp++;
    chk_letter("ovf", "......");
    // next letter straight from the word-wait: err clears at first press
    bus.key = 1'b1; wait_ticks(4);
    chk("ovf.err_clr", bus.err, 0);
    wait_ticks(20); bus.key = 1'b0;
    wait_ticks(30);
    cv_exp++;
    chk_letter("T", "-");
    wait_ticks(34); wg_exp++;

    // stuck key: err rises when the press reaches 7U = 56 ticks
    bus.key = 1'b1;
    wait_ticks(50);
    chk("stuck.err50", bus.err, 0);
    wait_ticks(8);
    chk("stuck.err58", bus.err, 1);
    chk("stuck.len", bus.sym_len, 0);
    wait_ticks(2);
    bus.key = 1'b0;
    wait_ticks(30);
    cv_exp++;
    chk("stuck.cv", cv_cnt, cv_exp);
    chk("stuck.code", last_code, 63);
    chk("stuck.len2", bus.sym_len, 0);
    wait_ticks(34); wg_exp++;
    chk("stuck.wg", wg_cnt, wg_exp);

    // 1-tick glitch in IDLE: nothing recorded, no pulses
    bus.key = 1'b1; wait_ticks(1); bus.key = 1'b0;
    wait_ticks(80);
    chk("glitch.cv", cv_cnt, cv_exp);
    chk("glitch.wg", wg_cnt, wg_exp);
    chk("glitch.len", bus.sym_len, 0);

    // reset in SPACE after two symbols
    send_letter(".-", 8, 24, 8, 4, 1'b0);
    chk("prerst.len", bus.sym_len, 2);
    rst = 1'b0;
    #1;
    chk("midrst.bits", bus.sym_bits, 0);
    chk("midrst.len", bus.sym_len, 0);
    chk("midrst.code", bus.char_code, 0);
    chk("midrst.pulses", {bus.char_valid, bus.word_gap, bus.err}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_ticks(80);
    chk("postrst.cv", cv_cnt, cv_exp);
    chk("postrst.wg", wg_cnt, wg_exp);

    // randomized letters, half from the alphabet, half arbitrary 1..6 symbols
    for (int l = 0; l < 12; l++) begin
      string pat;
      int n;
      pat = "";
      if ($urandom_range(0, 1) == 1) begin
        pat = morse_tbl[$urandom_range(0, 35)];
      end else begin
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) pat = {pat, ($urandom_range(0, 1) == 1) ? "-" : "."};
      end
      send_letter(pat, 0, 0, 0, $urandom_range(30, 50), 1'b1);
      cv_exp++;
      chk_letter($sformatf("rnd%0d", l), pat);
      if ($urandom_range(0, 1) == 1) begin
        wait_ticks(30);
        wg_exp++;
        chk($sformatf("rnd%0d.wg", l), wg_cnt, wg_exp);
      end
    end
    wait_ticks(60);
    wg_exp++;
    chk("final.cv", cv_cnt, cv_exp);
    chk("final.wg", wg_cnt, wg_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
